// File: rtl/icache_fetch_port_if.sv
// Fetcher and memory-controller fetch-port signals of the instruction cache.
// master: cache side; slave: fetcher/memory side.
interface icache_fetch_port_if;
    logic         req_from_fch;
    logic [31:0]  pc_from_fch;
    logic         inst_valid_to_fch;
    logic [31:0]  inst_to_fch;
    logic         enable_sign_to_mem;
    logic [31:0]  pc_to_mem;
    logic         finish_sign_from_mem;
    logic [127:0] inst_block_from_mem;

    modport master (
        input  req_from_fch, pc_from_fch, finish_sign_from_mem, inst_block_from_mem,
        output inst_valid_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
    );

    modport slave (
        output req_from_fch, pc_from_fch, finish_sign_from_mem, inst_block_from_mem,
        input  inst_valid_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
    );
endinterface

// File: rtl/icache_fetch_port.sv
// Direct-mapped I-cache: hit answers 1 cycle after the request, miss refills a 128-bit block.
// rdy low freezes everything; requests seen during a refill or on the response cycle are ignored.
module icache_fetch_port #(
    parameter int INDEX_BITS = 4,
    parameter int BLOCK_BITS = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clear_sign,
    icache_fetch_port_if.master bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state_q, state_n;
    logic                   discard_q, discard_n;
    logic [31:2]            pc_q, pc_n;
    logic                   inst_valid_q, inst_valid_n;
    logic [31:0]            inst_q, inst_n;
    logic                   mem_en_q, mem_en_n;
    logic [31:0]            mem_pc_q, mem_pc_n;
    logic                   fill_en;

    logic [LINES-1:0]       valid_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [BLOCK_BITS-1:0]  data_q [LINES];

    logic [INDEX_BITS-1:0]  req_idx, fill_idx;
    logic [TAG_BITS-1:0]    req_tag, fill_tag;
    logic [BLOCK_BITS-1:0]  req_line;
    logic                   hit;
    logic [31:0]            hit_word, fill_word;
    logic [1:0]             unused_byte_off;

    assign unused_byte_off = bus.pc_from_fch[1:0];

    assign req_idx  = bus.pc_from_fch[3+INDEX_BITS:4];
    assign req_tag  = bus.pc_from_fch[31:4+INDEX_BITS];
    assign req_line = data_q[req_idx];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_word = req_line[{bus.pc_from_fch[3:2], 5'b0} +: 32];

    assign fill_idx  = pc_q[3+INDEX_BITS:4];
    assign fill_tag  = pc_q[31:4+INDEX_BITS];
    // The missed word comes straight off the memory bus, not from the line being written.
    assign fill_word = bus.inst_block_from_mem[{pc_q[3:2], 5'b0} +: 32];

    always_comb begin
        state_n      = state_q;
        discard_n    = discard_q;
        pc_n         = pc_q;
        inst_valid_n = 1'b0;
        inst_n       = inst_q;
        mem_en_n     = 1'b0;
        mem_pc_n     = mem_pc_q;
        fill_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_from_fch && !clear_sign && !inst_valid_q) begin
                    pc_n = bus.pc_from_fch[31:2];
                    if (hit) begin
                        inst_valid_n = 1'b1;
                        inst_n       = hit_word;
                    end else begin
                        mem_en_n = 1'b1;
                        mem_pc_n = {bus.pc_from_fch[31:4], 4'b0000};
                        state_n  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (clear_sign)
                    discard_n = 1'b1;
                if (bus.finish_sign_from_mem) begin
                    fill_en = 1'b1;
                    if (!discard_q && !clear_sign) begin
                        inst_valid_n = 1'b1;
                        inst_n       = fill_word;
                    end
                    discard_n = 1'b0;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            discard_q    <= 1'b0;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_pc_q     <= '0;
            valid_q      <= '0;
        end else if (rdy) begin
            state_q      <= state_n;
            discard_q    <= discard_n;
            pc_q         <= pc_n;
            inst_valid_q <= inst_valid_n;
            inst_q       <= inst_n;
            mem_en_q     <= mem_en_n;
            mem_pc_q     <= mem_pc_n;
            if (fill_en)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.inst_block_from_mem;
        end
    end

    assign bus.inst_valid_to_fch  = inst_valid_q;
    assign bus.inst_to_fch        = inst_q;
    assign bus.enable_sign_to_mem = mem_en_q;
    assign bus.pc_to_mem          = mem_pc_q;
endmodule

// File: tb/tb_icache_fetch_port.sv
// Directed bench for icache_fetch_port: misses, hits, eviction, flushes, reset and stalls.
module tb_icache_fetch_port;
    logic clk = 1'b0;
    logic rst, rdy, clear_sign;
    int   checks = 0;
    int   errors = 0;

    icache_fetch_port_if ifc ();

    icache_fetch_port #(.INDEX_BITS(4), .BLOCK_BITS(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clear_sign (clear_sign),
        .bus        (ifc.master)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] BLK_A = {32'h33, 32'h22, 32'h11, 32'h00};
    localparam logic [127:0] BLK_B = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] BLK_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] BLK_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear_sign = 1'b0;
        ifc.req_from_fch = 1'b0; ifc.pc_from_fch = '0;
        ifc.finish_sign_from_mem = 1'b0; ifc.inst_block_from_mem = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.inst_valid_to_fch); end
        checks++; if (ifc.inst_to_fch !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", ifc.inst_to_fch); end
        checks++; if (ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", ifc.enable_sign_to_mem); end
        checks++; if (ifc.pc_to_mem !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", ifc.pc_to_mem); end
    endtask

    task automatic test_cold_miss();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0104;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1) begin errors++; $display("FAIL cold_en: got %b want 1", ifc.enable_sign_to_mem); end
        checks++; if (ifc.pc_to_mem !== 32'h0000_0100) begin errors++; $display("FAIL cold_pc: got %h want 00000100", ifc.pc_to_mem); end
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL cold_early_valid: got %b want 0", ifc.inst_valid_to_fch); end
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL cold_en_pulse: got %b want 0", ifc.enable_sign_to_mem); end
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_A;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b1) begin errors++; $display("FAIL cold_valid: got %b want 1", ifc.inst_valid_to_fch); end
        checks++; if (ifc.inst_to_fch !== 32'h11) begin errors++; $display("FAIL cold_inst: got %h want 00000011", ifc.inst_to_fch); end
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL cold_resp_ignore: got %b want 0", ifc.inst_valid_to_fch); end
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_010C;
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1) begin errors++; $display("FAIL hit_valid: got %b want 1", ifc.inst_valid_to_fch); end
        checks++; if (ifc.inst_to_fch !== 32'h33) begin errors++; $display("FAIL hit_inst: got %h want 00000033", ifc.inst_to_fch); end
        checks++; if (ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL hit_no_mem: got %b want 0", ifc.enable_sign_to_mem); end
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %b want 0", ifc.inst_valid_to_fch); end
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_1100;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1 || ifc.pc_to_mem !== 32'h0000_1100) begin errors++; $display("FAIL evict_miss: got en=%b pc=%h want en=1 pc=00001100", ifc.enable_sign_to_mem, ifc.pc_to_mem); end
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_B;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hA0) begin errors++; $display("FAIL evict_fill: got v=%b inst=%h want v=1 inst=000000a0", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0100;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1 || ifc.pc_to_mem !== 32'h0000_0100) begin errors++; $display("FAIL evict_remiss: got en=%b pc=%h want en=1 pc=00000100", ifc.enable_sign_to_mem, ifc.pc_to_mem); end
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_A;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'h00) begin errors++; $display("FAIL evict_refill: got v=%b inst=%h want v=1 inst=00000000", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_flush_wait();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0200;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1 || ifc.pc_to_mem !== 32'h0000_0200) begin errors++; $display("FAIL flush_miss: got en=%b pc=%h want en=1 pc=00000200", ifc.enable_sign_to_mem, ifc.pc_to_mem); end
        clear_sign = 1'b1; ifc.req_from_fch = 1'b0;
        tick();
        clear_sign = 1'b0;
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_C;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL flush_no_resp: got %b want 0", ifc.inst_valid_to_fch); end
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b0 || ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL flush_quiet: got v=%b en=%b want 0 0", ifc.inst_valid_to_fch, ifc.enable_sign_to_mem); end
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0200;
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hC0 || ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL flush_hit: got v=%b inst=%h en=%b want 1 000000c0 0", ifc.inst_valid_to_fch, ifc.inst_to_fch, ifc.enable_sign_to_mem); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_clear_coincident();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0300;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1) begin errors++; $display("FAIL coin_miss: got %b want 1", ifc.enable_sign_to_mem); end
        ifc.req_from_fch = 1'b0;
        clear_sign = 1'b1; ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_D;
        tick();
        clear_sign = 1'b0; ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL coin_no_resp: got %b want 0", ifc.inst_valid_to_fch); end
        tick();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0304;
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hD1) begin errors++; $display("FAIL coin_filled: got v=%b inst=%h want 1 000000d1", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0308; clear_sign = 1'b1;
        tick();
        clear_sign = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b0 || ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL clear_hit: got v=%b en=%b want 0 0", ifc.inst_valid_to_fch, ifc.enable_sign_to_mem); end
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hD2) begin errors++; $display("FAIL clear_then_hit: got v=%b inst=%h want 1 000000d2", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_rst_wait();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0400;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1) begin errors++; $display("FAIL rstw_miss: got %b want 1", ifc.enable_sign_to_mem); end
        ifc.req_from_fch = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ifc.enable_sign_to_mem !== 1'b0 || ifc.pc_to_mem !== 32'h0 || ifc.inst_to_fch !== 32'h0) begin errors++; $display("FAIL rstw_outputs: got en=%b pc=%h inst=%h want 0 0 0", ifc.enable_sign_to_mem, ifc.pc_to_mem, ifc.inst_to_fch); end
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_C;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL rstw_stale_finish: got %b want 0", ifc.inst_valid_to_fch); end
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0304;
        tick();
        checks++; if (ifc.enable_sign_to_mem !== 1'b1 || ifc.pc_to_mem !== 32'h0000_0300 || ifc.inst_valid_to_fch !== 1'b0) begin errors++; $display("FAIL rstw_invalid: got en=%b pc=%h v=%b want 1 00000300 0", ifc.enable_sign_to_mem, ifc.pc_to_mem, ifc.inst_valid_to_fch); end
        ifc.finish_sign_from_mem = 1'b1; ifc.inst_block_from_mem = BLK_D;
        tick();
        ifc.finish_sign_from_mem = 1'b0;
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hD1) begin errors++; $display("FAIL rstw_refill: got v=%b inst=%h want 1 000000d1", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        tick();
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    task automatic test_rdy_stall();
        ifc.req_from_fch = 1'b1; ifc.pc_from_fch = 32'h0000_0308; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifc.inst_valid_to_fch !== 1'b0 || ifc.inst_to_fch !== 32'hD1) begin errors++; $display("FAIL stall_hold_%0d: got v=%b inst=%h want 0 000000d1", i, ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        end
        rdy = 1'b1;
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hD2) begin errors++; $display("FAIL stall_resp: got v=%b inst=%h want 1 000000d2", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        rdy = 1'b0;
        tick(); tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b1 || ifc.inst_to_fch !== 32'hD2) begin errors++; $display("FAIL stall_valid_held: got v=%b inst=%h want 1 000000d2", ifc.inst_valid_to_fch, ifc.inst_to_fch); end
        rdy = 1'b1;
        tick();
        checks++; if (ifc.inst_valid_to_fch !== 1'b0 || ifc.enable_sign_to_mem !== 1'b0) begin errors++; $display("FAIL stall_release: got v=%b en=%b want 0 0", ifc.inst_valid_to_fch, ifc.enable_sign_to_mem); end
        ifc.req_from_fch = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_wait();
        test_clear_coincident();
        test_rst_wait();
        test_rdy_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
